pending_encoder: RTL and testbench

Sequential index-to-one-hot encoder that maintains a pending-request vector.
- **Write side:** producers deliver binary indices over a valid/ready stream. Each index is encoded to one-hot and OR-ed into a registered pending vector.
- **Consume side:** indices are cleared individually, or drained lowest-first by a flush state machine that emits one index per cycle.
- **Placement:** it feeds the lowest-index-first priority decoder, supplying the `pending` vector that the decoder resolves.

---
 rtl/pending_encoder_pkg.sv | 21 ++
 rtl/pending_encoder_onehot_enc.sv | 17 +
 rtl/pending_encoder.sv | 113 +++++++++++
 tb/tb_pending_encoder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pending_encoder_pkg.sv
// Shared definitions for the pending-request encoder and its downstream priority decoder.
package pending_encoder_pkg;

    localparam int unsigned MAX_WIDTH = 64;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    // Lowest-index-first priority rule; must match the downstream decoder.
    function automatic int unsigned lowest_set_idx(input logic [MAX_WIDTH-1:0] vec);
        int unsigned idx;
        idx = 0;
        for (int i = MAX_WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) idx = unsigned'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/pending_encoder_onehot_enc.sv
// Binary index to one-hot encoder; in_range_c is low when idx has no line.
module onehot_enc #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDXW  = $clog2(WIDTH)
) (
    input  logic [IDXW-1:0]  idx,
    output logic [WIDTH-1:0] onehot_c,
    output logic             in_range_c
);

    localparam int unsigned FULLW = 1 << IDXW;

    // Out-of-range indices shift the bit past WIDTH, leaving an all-zero vector.
    assign onehot_c   = WIDTH'(FULLW'(1) << idx);
    assign in_range_c = |onehot_c;

endmodule

// File: rtl/pending_encoder.sv
// Pending-request vector: one-hot sets/clears in IDLE, lowest-first drain in FLUSH.
module pending_encoder
    import pending_encoder_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDXW  = $clog2(WIDTH),
    parameter int unsigned CNTW  = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_valid,
    input  logic [IDXW-1:0]  set_idx,
    output logic             set_ready,
    input  logic             clr_valid,
    input  logic [IDXW-1:0]  clr_idx,
    input  logic             flush,
    output logic             drain_valid,
    output logic [IDXW-1:0]  drain_idx,
    output logic [WIDTH-1:0] pending,
    output logic [WIDTH-1:0] last_onehot,
    output logic [CNTW-1:0]  count,
    output logic             empty,
    output logic             full,
    output logic             dup_err,
    output logic             range_err,
    input  logic             err_clr
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] set_oh_c, clr_oh_c, set_hit_c, clr_hit_c, drain_oh_c;
    logic             set_in_c, clr_in_c;
    logic [WIDTH-1:0] pending_d, last_d;
    logic [CNTW-1:0]  count_d;
    logic             newly_c, cleared_c, dup_ev_c, rng_ev_c, dup_d, rng_d;

    onehot_enc #(.WIDTH(WIDTH), .IDXW(IDXW)) u_set_enc (
        .idx        (set_idx),
        .onehot_c   (set_oh_c),
        .in_range_c (set_in_c)
    );

    onehot_enc #(.WIDTH(WIDTH), .IDXW(IDXW)) u_clr_enc (
        .idx        (clr_idx),
        .onehot_c   (clr_oh_c),
        .in_range_c (clr_in_c)
    );

    // Isolate the lowest pending bit; same rule as lowest_set_idx.
    assign drain_oh_c  = pending & (~pending + WIDTH'(1));
    assign set_ready   = (state_q == ST_IDLE);
    assign drain_valid = (state_q == ST_FLUSH);
    assign drain_idx   = drain_valid ? IDXW'(lowest_set_idx(MAX_WIDTH'(pending))) : '0;

    // Next-state and next register values.
    always_comb begin
        state_d   = state_q;
        pending_d = pending;
        last_d    = last_onehot;
        count_d   = count;
        set_hit_c = '0;
        clr_hit_c = '0;
        newly_c   = 1'b0;
        cleared_c = 1'b0;
        dup_ev_c  = 1'b0;
        rng_ev_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (set_valid && set_in_c) set_hit_c = set_oh_c;
                if (clr_valid && clr_in_c) clr_hit_c = clr_oh_c;
                newly_c   = |(set_hit_c & ~pending);
                cleared_c = |(clr_hit_c & pending & ~set_hit_c);
                dup_ev_c  = |(set_hit_c & pending);
                rng_ev_c  = (set_valid && !set_in_c) || (clr_valid && !clr_in_c);
                pending_d = (pending & ~clr_hit_c) | set_hit_c;
                if (|set_hit_c) last_d = set_hit_c;
                count_d   = count + CNTW'(newly_c) - CNTW'(cleared_c);
                if (flush && !empty) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                pending_d = pending & ~drain_oh_c;
                count_d   = count - CNTW'(1);
                if (count == CNTW'(1)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // An error event in the same cycle as err_clr keeps the flag set.
        dup_d = dup_ev_c | (dup_err & ~err_clr);
        rng_d = rng_ev_c | (range_err & ~err_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pending     <= '0;
            last_onehot <= '0;
            count       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            dup_err     <= 1'b0;
            range_err   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending     <= pending_d;
            last_onehot <= last_d;
            count       <= count_d;
            empty       <= (count_d == '0);
            full        <= (count_d == CNTW'(WIDTH));
            dup_err     <= dup_d;
            range_err   <= rng_d;
        end
    end

endmodule

// File: tb/tb_pending_encoder.sv
// Scoreboard bench for pending_encoder against a bit-array reference model.
module tb_pending_encoder;

    localparam int unsigned W    = 6;
    localparam int unsigned IDXW = $clog2(W);
    localparam int unsigned CNTW = $clog2(W + 1);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            set_valid = 1'b0, clr_valid = 1'b0, flush = 1'b0, err_clr = 1'b0;
    logic [IDXW-1:0] set_idx = '0, clr_idx = '0;
    logic            set_ready, drain_valid, empty, full, dup_err, range_err;
    logic [IDXW-1:0] drain_idx;
    logic [W-1:0]    pending, last_onehot;
    logic [CNTW-1:0] count;

    pending_encoder #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .set_valid(set_valid), .set_idx(set_idx), .set_ready(set_ready),
        .clr_valid(clr_valid), .clr_idx(clr_idx), .flush(flush),
        .drain_valid(drain_valid), .drain_idx(drain_idx),
        .pending(pending), .last_onehot(last_onehot), .count(count),
        .empty(empty), .full(full), .dup_err(dup_err), .range_err(range_err),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            sr, dv, emp, ful, dup, rng;
        logic [IDXW-1:0] di;
        logic [W-1:0]    pend, last;
        logic [CNTW-1:0] cnt;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model state
    bit           mpend[W];
    bit           mflush, mdup, mrng;
    logic [W-1:0] mlast;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int mcount();
        int c = 0;
        for (int i = 0; i < W; i++) c += int'(mpend[i]);
        return c;
    endfunction

    function automatic int mlowest();
        for (int i = 0; i < W; i++) if (mpend[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < W; i++) mpend[i] = 1'b0;
        mflush = 1'b0; mdup = 1'b0; mrng = 1'b0; mlast = '0;
    endtask

    function automatic exp_t snapshot();
        exp_t e;
        int   c = mcount();
        for (int i = 0; i < W; i++) e.pend[i] = mpend[i];
        e.sr   = !mflush;
        e.dv   = mflush;
        e.di   = mflush ? IDXW'(mlowest()) : '0;
        e.last = mlast;
        e.cnt  = CNTW'(c);
        e.emp  = (c == 0);
        e.ful  = (c == int'(W));
        e.dup  = mdup;
        e.rng  = mrng;
        return e;
    endfunction

    task automatic model_step(input logic sv, input logic [IDXW-1:0] si, input logic cv,
                              input logic [IDXW-1:0] ci, input logic fl, input logic ec);
        int c = mcount();
        bit dupev = 1'b0, rngev = 1'b0;
        if (!mflush) begin
            if (sv && int'(si) < int'(W) && mpend[si]) dupev = 1'b1;
            if (cv) begin
                if (int'(ci) >= int'(W)) rngev = 1'b1;
                else if (!(sv && si == ci)) mpend[ci] = 1'b0;
            end
            if (sv) begin
                if (int'(si) >= int'(W)) rngev = 1'b1;
                else begin
                    mpend[si] = 1'b1;
                    mlast = '0;
                    mlast[si] = 1'b1;
                end
            end
            if (fl && c != 0) mflush = 1'b1;
        end else begin
            mpend[mlowest()] = 1'b0;
            if (mcount() == 0) mflush = 1'b0;
        end
        mdup = dupev || (mdup && !ec);
        mrng = rngev || (mrng && !ec);
    endtask

    // Drive one cycle of inputs and record what the outputs must show during it.
    task automatic drive(input logic sv, input logic [IDXW-1:0] si, input logic cv,
                         input logic [IDXW-1:0] ci, input logic fl, input logic ec);
        @(posedge clk); #1;
        set_valid = sv; set_idx = si; clr_valid = cv; clr_idx = ci; flush = fl; err_clr = ec;
        q.push_back(snapshot());
        model_step(sv, si, cv, ci, fl, ec);
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    // Monitor: compares every observed cycle against the queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && q.size() > 0) begin
            e = q.pop_front();
            check("set_ready",   32'(set_ready),   32'(e.sr));
            check("drain_valid", 32'(drain_valid), 32'(e.dv));
            check("drain_idx",   32'(drain_idx),   32'(e.di));
            check("pending",     32'(pending),     32'(e.pend));
            check("last_onehot", 32'(last_onehot), 32'(e.last));
            check("count",       32'(count),       32'(e.cnt));
            check("empty",       32'(empty),       32'(e.emp));
            check("full",        32'(full),        32'(e.ful));
            check("dup_err",     32'(dup_err),     32'(e.dup));
            check("range_err",   32'(range_err),   32'(e.rng));
        end
    end

    initial begin
        model_reset();
        #12;
        check("rst_pending", 32'(pending), 32'(0));
        check("rst_empty", 32'(empty), 32'(1));
        check("rst_set_ready", 32'(set_ready), 32'(1));
        check("rst_drain_valid", 32'(drain_valid), 32'(0));
        @(negedge clk); rst_n = 1'b1;

        // Basic sets
        drive(1'b1, 3'd3, 1'b0, '0, 1'b0, 1'b0);
        drive(1'b1, 3'd5, 1'b0, '0, 1'b0, 1'b0);
        idle();
        check("basic_pending", 32'(pending), 32'(6'b10_1000));
        check("basic_count", 32'(count), 32'(2));
        check("basic_last", 32'(last_onehot), 32'(6'b10_0000));

        // Duplicate and err_clr
        drive(1'b0, '0, 1'b1, 3'd5, 1'b0, 1'b0);
        drive(1'b1, 3'd3, 1'b0, '0, 1'b0, 1'b0);
        idle();
        check("dup_flag", 32'(dup_err), 32'(1));
        check("dup_count", 32'(count), 32'(1));
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        idle();
        check("dup_cleared", 32'(dup_err), 32'(0));

        // Simultaneous set/clear
        drive(1'b1, 3'd5, 1'b1, 3'd3, 1'b0, 1'b0);
        drive(1'b1, 3'd5, 1'b1, 3'd5, 1'b0, 1'b0);
        idle();
        check("same_idx_pending", 32'(pending), 32'(6'b10_0000));
        check("same_idx_count", 32'(count), 32'(1));
        drive(1'b1, 3'd2, 1'b1, 3'd5, 1'b0, 1'b1);
        idle();
        check("diff_idx_pending", 32'(pending), 32'(6'b00_0100));

        // Flush drain of 010010
        drive(1'b1, 3'd1, 1'b1, 3'd2, 1'b0, 1'b0);
        drive(1'b1, 3'd4, 1'b0, '0, 1'b0, 1'b0);
        idle();
        check("flush_pre", 32'(pending), 32'(6'b01_0010));
        drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        drive(1'b1, 3'd0, 1'b1, 3'd4, 1'b0, 1'b0);
        check("drain0_idx", 32'(drain_idx), 32'(1));
        check("drain0_ready", 32'(set_ready), 32'(0));
        idle();
        check("drain1_idx", 32'(drain_idx), 32'(4));
        check("drain1_ready", 32'(set_ready), 32'(0));
        idle();
        check("drain_done_ready", 32'(set_ready), 32'(1));
        check("drain_done_empty", 32'(empty), 32'(1));
        check("drain_done_valid", 32'(drain_valid), 32'(0));
        drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        idle();
        check("flush_empty_ignored", 32'(set_ready), 32'(1));

        // Range errors
        drive(1'b1, 3'd7, 1'b0, '0, 1'b0, 1'b0);
        idle();
        check("range_set", 32'(range_err), 32'(1));
        check("range_pending", 32'(pending), 32'(0));
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b1, 3'd6, 1'b0, 1'b0);
        idle();
        check("range_clr", 32'(range_err), 32'(1));

        // Fill to full, then one more set
        for (int i = 0; i < int'(W); i++) drive(1'b1, IDXW'(i), 1'b0, '0, 1'b0, 1'b1);
        idle();
        check("full_flag", 32'(full), 32'(1));
        check("full_dup_clear", 32'(dup_err), 32'(0));
        drive(1'b1, 3'd2, 1'b0, '0, 1'b0, 1'b0);
        idle();
        check("full_dup", 32'(dup_err), 32'(1));
        check("full_count", 32'(count), 32'(W));

        // Reset during the second drain cycle
        drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        idle();
        idle();
        check("mid_drain_idx", 32'(drain_idx), 32'(1));
        #2;
        rst_n = 1'b0;
        q.delete();
        model_reset();
        #1;
        check("rst_mid_pending", 32'(pending), 32'(0));
        check("rst_mid_drain_valid", 32'(drain_valid), 32'(0));
        @(negedge clk); #2;
        rst_n = 1'b1;
        set_valid = 1'b0; clr_valid = 1'b0; flush = 1'b0; err_clr = 1'b0;
        idle();
        check("rst_mid_idle", 32'(set_ready), 32'(1));

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            drive(logic'($urandom_range(0, 1)), IDXW'($urandom_range(0, 7)),
                  ($urandom_range(0, 9) < 3), IDXW'($urandom_range(0, 7)),
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0));
        end
        idle();
        idle();
        @(negedge clk); #1;
        check("queue_drained", 32'(q.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
